// File: rtl/sht40_pkg.sv
// Shared constants and FSM encoding for the SHT40 response path.
package sht40_pkg;

  localparam logic [7:0]  CRC8_POLY   = 8'h31;
  localparam logic [7:0]  CRC8_INIT   = 8'hFF;
  localparam int unsigned FRAME_BYTES = 6;

  localparam logic [2:0] IDX_T_MSB  = 3'd0;
  localparam logic [2:0] IDX_T_LSB  = 3'd1;
  localparam logic [2:0] IDX_T_CRC  = 3'd2;
  localparam logic [2:0] IDX_RH_MSB = 3'd3;
  localparam logic [2:0] IDX_RH_LSB = 3'd4;
  localparam logic [2:0] IDX_RH_CRC = 3'(FRAME_BYTES - 1);

  typedef enum logic {
    COLLECT,
    DONE
  } state_t;

endpackage

// File: rtl/sht40_crc8.sv
// Combinational CRC-8 step (poly 0x31, MSB first, no reflection) over one data byte.
module sht40_crc8
  import sht40_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/sht40_frame_decoder.sv
// Decodes the 6-byte SHT40 measurement response and publishes temp/RH words with held ready levels.
// Define SHT40_CRC_CHECK_EN to check each word's CRC-8; otherwise CRC bytes are only counted.
module sht40_frame_decoder
  import sht40_pkg::*;
#(
  parameter int unsigned READY_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic [15:0] o_temp,
  output logic [15:0] o_rh,
  output logic        o_r_temp,
  output logic        o_r_rh,
  output logic        o_crc_err,
  output logic        o_overrun
);

  localparam int unsigned HW = $clog2(READY_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(READY_HOLD);

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_eff;
  logic          accept, last_byte, overrun_d;
  logic          pub_q;
  logic [15:0]   shadow_t, shadow_rh;
  logic          t_ok_q, rh_ok_q;
  logic [HW-1:0] hold_t_q, hold_rh_q;
  logic          regap_t_q, regap_rh_q;

  // A start in the same cycle as a byte makes that byte idx0 of the new frame.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    overrun_d = 1'b0;
    idx_eff   = i_start ? IDX_T_MSB : idx_q;
    if (i_start) state_d = COLLECT;
    if (i_byte_valid) begin
      if (i_start || state_q == COLLECT) begin
        accept = 1'b1;
        if (idx_eff == IDX_RH_CRC) state_d = DONE;
      end else begin
        overrun_d = 1'b1;
      end
    end
    last_byte = accept && (idx_eff == IDX_RH_CRC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= IDX_T_MSB;
      pub_q     <= 1'b0;
      o_overrun <= 1'b0;
      shadow_t  <= '0;
      shadow_rh <= '0;
    end else begin
      state_q   <= state_d;
      pub_q     <= last_byte;
      o_overrun <= overrun_d;
      if (accept) begin
        idx_q <= last_byte ? IDX_T_MSB : idx_eff + 3'd1;
        case (idx_eff)
          IDX_T_MSB:  shadow_t[15:8]  <= i_byte;
          IDX_T_LSB:  shadow_t[7:0]   <= i_byte;
          IDX_RH_MSB: shadow_rh[15:8] <= i_byte;
          IDX_RH_LSB: shadow_rh[7:0]  <= i_byte;
          default:    ;
        endcase
      end else if (i_start) begin
        idx_q <= IDX_T_MSB;
      end
    end
  end

`ifdef SHT40_CRC_CHECK_EN
  logic [7:0] crc_q, crc_eff, crc_next;

  assign crc_eff = i_start ? CRC8_INIT : crc_q;

  sht40_crc8 u_crc8 (
    .crc_in  (crc_eff),
    .data    (i_byte),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= CRC8_INIT;
      t_ok_q    <= 1'b0;
      rh_ok_q   <= 1'b0;
      o_crc_err <= 1'b0;
    end else begin
      o_crc_err <= pub_q && !(t_ok_q && rh_ok_q);
      if (accept) begin
        case (idx_eff)
          IDX_T_CRC: begin
            t_ok_q <= (i_byte == crc_eff);
            crc_q  <= CRC8_INIT;
          end
          IDX_RH_CRC: begin
            rh_ok_q <= (i_byte == crc_eff);
            crc_q   <= CRC8_INIT;
          end
          default: crc_q <= crc_next;
        endcase
      end else if (i_start) begin
        crc_q <= CRC8_INIT;
      end
    end
  end
`else
  assign t_ok_q    = 1'b1;
  assign rh_ok_q   = 1'b1;
  assign o_crc_err = 1'b0;
`endif

  // Re-publish during an active hold drops ready for one cycle (regap) before reloading.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_temp     <= '0;
      o_rh       <= '0;
      hold_t_q   <= '0;
      hold_rh_q  <= '0;
      regap_t_q  <= 1'b0;
      regap_rh_q <= 1'b0;
    end else begin
      if (pub_q && t_ok_q) begin
        o_temp <= shadow_t;
        if (hold_t_q != '0) begin
          hold_t_q  <= '0;
          regap_t_q <= 1'b1;
        end else begin
          hold_t_q <= HOLD_LOAD;
        end
      end else if (regap_t_q) begin
        hold_t_q  <= HOLD_LOAD;
        regap_t_q <= 1'b0;
      end else if (hold_t_q != '0) begin
        hold_t_q <= hold_t_q - 1'b1;
      end

      if (pub_q && rh_ok_q) begin
        o_rh <= shadow_rh;
        if (hold_rh_q != '0) begin
          hold_rh_q  <= '0;
          regap_rh_q <= 1'b1;
        end else begin
          hold_rh_q <= HOLD_LOAD;
        end
      end else if (regap_rh_q) begin
        hold_rh_q  <= HOLD_LOAD;
        regap_rh_q <= 1'b0;
      end else if (hold_rh_q != '0) begin
        hold_rh_q <= hold_rh_q - 1'b1;
      end
    end
  end

  assign o_r_temp = (hold_t_q != '0);
  assign o_r_rh   = (hold_rh_q != '0);

endmodule

// File: tb/tb_sht40_frame_decoder.sv
// Directed self-checking bench for sht40_frame_decoder; expectations follow SHT40_CRC_CHECK_EN if defined.
module tb_sht40_frame_decoder;

  logic        clk = 1'b0;
  logic        rst, i_start, i_byte_valid;
  logic [7:0]  i_byte;
  logic [15:0] o_temp, o_rh;
  logic        o_r_temp, o_r_rh, o_crc_err, o_overrun;

  int errors = 0;
  int checks = 0;
  int nt, nr, ne, no;

  always #5 clk = ~clk;

  sht40_frame_decoder #(.READY_HOLD(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_temp       (o_temp),
    .o_rh         (o_rh),
    .o_r_temp     (o_r_temp),
    .o_r_rh       (o_r_rh),
    .o_crc_err    (o_crc_err),
    .o_overrun    (o_overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic st);
    i_byte       = b;
    i_byte_valid = 1'b1;
    i_start      = st;
    tick();
    i_byte_valid = 1'b0;
    i_start      = 1'b0;
  endtask

  task automatic frame(input logic st, input logic [7:0] b0, b1, b2, b3, b4, b5);
    send(b0, st);
    send(b1, 1'b0);
    send(b2, 1'b0);
    send(b3, 1'b0);
    send(b4, 1'b0);
    send(b5, 1'b0);
  endtask

  // Counts high samples of each flag from the current sample until all are low (bounded).
  task automatic measure;
    nt = 0; nr = 0; ne = 0; no = 0;
    for (int k = 0; k < 40; k++) begin
      if (!(o_r_temp || o_r_rh || o_crc_err || o_overrun)) break;
      nt += int'(o_r_temp);
      nr += int'(o_r_rh);
      ne += int'(o_crc_err);
      no += int'(o_overrun);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("rst_temp", 32'(o_temp), 32'h0);
    check("rst_rh", 32'(o_rh), 32'h0);
    check("rst_ready", {30'b0, o_r_temp, o_r_rh}, 32'h0);
    check("rst_pulses", {30'b0, o_crc_err, o_overrun}, 32'h0);

    // 1: good frame BEEF/BEEF
    i_start = 1'b1; tick(); i_start = 1'b0;
    frame(1'b0, 8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92);
    check("t1_ready_before_pub", {30'b0, o_r_temp, o_r_rh}, 32'h0);
    tick();
    check("t1_temp", 32'(o_temp), 32'hBEEF);
    check("t1_rh", 32'(o_rh), 32'hBEEF);
    measure();
    check("t1_hold_t", nt, 16);
    check("t1_hold_rh", nr, 16);
    check("t1_crc_err", ne, 0);

    // 2: temp good, RH CRC bad
    frame(1'b1, 8'h00, 8'h00, 8'h81, 8'hBE, 8'hEF, 8'h93);
    tick();
    check("t2_temp", 32'(o_temp), 32'h0000);
    check("t2_rh", 32'(o_rh), 32'hBEEF);
    measure();
    check("t2_hold_t", nt, 16);
`ifdef SHT40_CRC_CHECK_EN
    check("t2_hold_rh", nr, 0);
    check("t2_crc_err", ne, 1);
`else
    check("t2_hold_rh", nr, 16);
    check("t2_crc_err", ne, 0);
`endif

    // 3: aborted frame then full 0000/0000 frame
    send(8'hBE, 1'b1);
    send(8'hEF, 1'b0);
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    tick();
    check("t3_abort_quiet", {29'b0, o_r_temp, o_r_rh, o_crc_err}, 32'h0);
    check("t3_abort_rh", 32'(o_rh), 32'hBEEF);
    frame(1'b0, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h81);
    tick();
    check("t3_temp", 32'(o_temp), 32'h0000);
    check("t3_rh", 32'(o_rh), 32'h0000);
    measure();
    check("t3_hold_t", nt, 16);
    check("t3_hold_rh", nr, 16);
    check("t3_crc_err", ne, 0);

    // 4: re-publish during active hold (start coincides with first byte)
    frame(1'b1, 8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92);
    tick();
    check("t4_first_temp", 32'(o_temp), 32'hBEEF);
    frame(1'b1, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h81);
    check("t4_hold_active", {30'b0, o_r_temp, o_r_rh}, 32'h3);
    tick();
    check("t4_gap", {30'b0, o_r_temp, o_r_rh}, 32'h0);
    check("t4_temp", 32'(o_temp), 32'h0000);
    tick();
    measure();
    check("t4_hold_t", nt, 16);
    check("t4_hold_rh", nr, 16);

    // 5: overrun byte after a complete frame
    frame(1'b1, 8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92);
    tick();
    measure();
    check("t5_hold_t", nt, 16);
    send(8'h55, 1'b0);
    check("t5_overrun", 32'(o_overrun), 32'h1);
    tick();
    check("t5_overrun_end", 32'(o_overrun), 32'h0);
    check("t5_temp", 32'(o_temp), 32'hBEEF);
    check("t5_rh", 32'(o_rh), 32'hBEEF);
    check("t5_quiet", {29'b0, o_r_temp, o_r_rh, o_crc_err}, 32'h0);

    // 6: reset mid-frame and mid-hold; frames open from reset without start
    send(8'h12, 1'b1);
    send(8'h34, 1'b0);
    send(8'h37, 1'b0);
    send(8'h56, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_temp", 32'(o_temp), 32'h0);
    check("t6_rst_rh", 32'(o_rh), 32'h0);
    frame(1'b0, 8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92);
    tick();
    check("t6_pub_after_rst", {o_temp, o_rh}, 32'hBEEF_BEEF);
    tick();
    tick();
    check("t6_in_hold", {30'b0, o_r_temp, o_r_rh}, 32'h3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_hold", {30'b0, o_r_temp, o_r_rh}, 32'h0);
    check("t6_rst_words", {o_temp, o_rh}, 32'h0);
    tick();
    check("t6_hold_stays_off", {30'b0, o_r_temp, o_r_rh}, 32'h0);
    frame(1'b0, 8'hBE, 8'hEF, 8'h92, 8'h00, 8'h00, 8'h81);
    tick();
    check("t6_final_words", {o_temp, o_rh}, 32'hBEEF_0000);
    measure();
    check("t6_hold_t", nt, 16);
    check("t6_hold_rh", nr, 16);
    check("t6_no_pulses", ne + no, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
